// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_N = 8;

endpackage : serial_adder_pkg

// File: rtl/fa_1.sv
// 1-bit full adder: s = x ^ y ^ rin, r = carry out.
module fa_1 (
    input  logic x,
    input  logic y,
    input  logic rin,
    output logic s,
    output logic r
);

    assign s = x ^ y ^ rin;
    assign r = (x & y) | (x & rin) | (y & rin);

endmodule : fa_1

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one fa_1 fed LSB first, carry held in a flop.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = SA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    sa_state_t        state_q, state_d;
    logic [N-1:0]     ra_q, ra_d;
    logic [N-1:0]     rb_q, rb_d;
    logic [N-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_r;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa_1 u_fa (
        .x   (ra_q[0]),
        .y   (rb_q[0]),
        .rin (c_q),
        .s   (fa_s),
        .r   (fa_r)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    ra_d    = a;
                    rb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d = {fa_s, sum_q[N-1:1]};
                c_d   = fa_r;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    // Counter parks on the last bit instead of wrapping.
                    state_d = DONE;
                    cout_d  = fa_r;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = c_q ^ fa_r;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Status outputs decode the state register only; no input reaches an output.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_adder
